// File: rtl/fpu_pkg.sv
// fpu_pkg: types and constants shared by the FPU response collector.
//   fpu_resp_t        - captured response, {flags, result}
//   FLG_*             - bit positions inside the 8-bit FPU flag vector
//   collector_state_e - collector control states
package fpu_pkg;

  localparam int FPU_DATA_W = 32;

  localparam int FLG_INF  = 7;
  localparam int FLG_SNAN = 6;
  localparam int FLG_QNAN = 5;
  localparam int FLG_INE  = 4;
  localparam int FLG_OVF  = 3;
  localparam int FLG_UNF  = 2;
  localparam int FLG_ZERO = 1;
  localparam int FLG_DBZ  = 0;

  typedef struct packed {
    logic [7:0]            flags;
    logic [FPU_DATA_W-1:0] result;
  } fpu_resp_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } collector_state_e;

endpackage

// File: rtl/fpu_resp_fifo.sv
// fpu_resp_fifo: synchronous first-word-fall-through FIFO.
//   clk, reset  - clock, synchronous active-high reset (pointers/count only)
//   push, wdata - write strobe and data; ignored when full
//   pop         - consume head; ignored when empty
//   rdata       - head entry, valid whenever empty is low
//   count       - entries held; full / empty status
module fpu_resp_fifo #(
  parameter  int WIDTH = 40,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries data only; it is never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fpu_resp_collector.sv
// fpu_resp_collector: tracks FPU issues, captures {flags, result} FPU_LATENCY
// cycles later into a credit-protected FIFO and drains it at end-of-message.
//   clk, reset            - clock, synchronous active-high reset
//   issue_valid/ready     - operation issue handshake toward the FPU
//   eom                   - end of message level; starts the drain
//   fpu_out, fpu_flags    - FPU result and flag vector, sampled on capture
//   resp_valid/ready/data - response stream, {flags, result}
//   in_flight, fifo_count - outstanding issues / buffered responses
//   done                  - drain finished, held until reset
//   proto_err             - sticky: issue attempted while not ready
module fpu_resp_collector
  import fpu_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int FPU_LATENCY = 4,
  parameter  int DEPTH       = 8,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int RW          = DATA_WIDTH + 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic                  eom,
  input  logic [DATA_WIDTH-1:0] fpu_out,
  input  logic [7:0]            fpu_flags,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [RW-1:0]         resp_data,
  output logic [CW-1:0]         in_flight,
  output logic [CW-1:0]         fifo_count,
  output logic                  done,
  output logic                  proto_err
);

  collector_state_e       state_q, state_d;
  logic [FPU_LATENCY-1:0] dl_q, dl_d;
  logic [CW-1:0]          in_flight_q, in_flight_d;
  logic                   proto_err_q, proto_err_d;

  logic [CW-1:0] fifo_cnt, fifo_cnt_nxt;
  logic [RW-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic          acc, capture, push, pop;
  logic [CW:0]   occupancy;

  // Credits: every outstanding issue owns a FIFO slot, so a capture always
  // finds room. Depends only on registered state and reset.
  assign occupancy   = {1'b0, in_flight_q} + {1'b0, fifo_cnt};
  assign issue_ready = (state_q == RUN) & ~reset & (occupancy < (CW+1)'(DEPTH));
  assign acc         = issue_valid & issue_ready;

  // Token leaving the last delay stage marks the edge the FPU result is valid.
  assign capture = dl_q[FPU_LATENCY-1] & ~reset;
  assign push    = capture & ~fifo_full;
  assign pop     = resp_valid & resp_ready;

  generate
    if (FPU_LATENCY == 1) begin : g_dl1
      assign dl_d = acc;
    end else begin : g_dln
      assign dl_d = {dl_q[FPU_LATENCY-2:0], acc};
    end
  endgenerate

  fpu_resp_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({fpu_flags, fpu_out}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-cycle counts let DONE be entered on the same edge the work empties.
  always_comb begin
    in_flight_d  = in_flight_q + CW'(acc) - CW'(capture);
    fifo_cnt_nxt = fifo_cnt + CW'(push) - CW'(pop & ~fifo_empty);
    proto_err_d  = proto_err_q | (issue_valid & ~issue_ready);
    state_d      = state_q;
    case (state_q)
      RUN:     if (eom) state_d = DRAIN;
      DRAIN:   if (in_flight_d == '0 && fifo_cnt_nxt == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      dl_q        <= '0;
      in_flight_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      in_flight_q <= in_flight_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Every output reads zero while reset is held.
  assign resp_valid = ~fifo_empty & ~reset;
  assign resp_data  = reset ? '0 : fifo_rdata;
  assign in_flight  = reset ? '0 : in_flight_q;
  assign fifo_count = reset ? '0 : fifo_cnt;
  assign done       = (state_q == DONE) & ~reset;
  assign proto_err  = proto_err_q & ~reset;

endmodule

// File: tb/tb_fpu_resp_collector.sv
module tb_fpu_resp_collector;
  import fpu_pkg::*;

  localparam int DW    = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset, issue_valid, issue_ready, eom;
  logic [DW-1:0] fpu_out;
  logic [7:0]    fpu_flags;
  logic          resp_valid, resp_ready;
  logic [DW+7:0] resp_data;
  logic [CW-1:0] in_flight, fifo_count;
  logic          done, proto_err;

  always #5 clk = ~clk;

  fpu_resp_collector #(
    .DATA_WIDTH (DW),
    .FPU_LATENCY(LAT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .eom        (eom),
    .fpu_out    (fpu_out),
    .fpu_flags  (fpu_flags),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .in_flight  (in_flight),
    .fifo_count (fifo_count),
    .done       (done),
    .proto_err  (proto_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: each accepted issue is a due time; captured responses
  // form an ordered queue; state 0=running, 1=draining, 2=finished.
  int         pend[$];
  logic [39:0] mq[$];
  int         mst   = 0;
  bit         mproto = 1'b0;
  int         cyc   = 0;

  logic        s_iv, s_rr, s_eom, s_rst;
  logic [31:0] s_fo;
  logic [7:0]  s_ff;

  function automatic bit m_ready();
    return (mst == 0) && ((pend.size() + mq.size()) < DEPTH);
  endfunction

  task automatic model_edge();
    bit rdy;
    bit took;
    if (s_rst) begin
      pend.delete();
      mq.delete();
      mst    = 0;
      mproto = 1'b0;
    end else begin
      rdy  = m_ready();
      took = s_iv && rdy;
      if (s_iv && !rdy) mproto = 1'b1;
      if (s_rr && mq.size() > 0) void'(mq.pop_front());
      if (pend.size() > 0 && pend[0] == cyc) begin
        void'(pend.pop_front());
        mq.push_back({s_ff, s_fo});
      end
      if (took) pend.push_back(cyc + LAT);
      if (mst == 0 && s_eom) mst = 1;
      else if (mst == 1 && pend.size() == 0 && mq.size() == 0) mst = 2;
    end
    cyc++;
  endtask

  task automatic check_outputs();
    if (reset) begin
      chk("rst_issue_ready", issue_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_in_flight", in_flight, 0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_done", done, 0);
      chk("rst_proto_err", proto_err, 0);
    end else begin
      chk("issue_ready", issue_ready, m_ready());
      chk("resp_valid", resp_valid, mq.size() > 0);
      if (mq.size() > 0) chk("resp_data", resp_data, mq[0]);
      chk("in_flight", in_flight, pend.size());
      chk("fifo_count", fifo_count, mq.size());
      chk("done", done, mst == 2);
      chk("proto_err", proto_err, mproto);
    end
  endtask

  task automatic step(input logic iv, input logic rr, input logic e, input logic r,
                      input logic [31:0] fo, input logic [7:0] ff);
    @(posedge clk);
    #1;
    model_edge();
    issue_valid = iv; resp_ready = rr; eom = e; reset = r;
    fpu_out = fo; fpu_flags = ff;
    s_iv = iv; s_rr = rr; s_eom = e; s_rst = r; s_fo = fo; s_ff = ff;
    #1;
    check_outputs();
  endtask

  task automatic step_r(input logic iv, input logic rr, input logic e, input logic r);
    step(iv, rr, e, r, $urandom, 8'($urandom));
  endtask

  task automatic step_p(input int piv, input int prr, input int prst);
    step_r($urandom_range(0, 99) < piv, $urandom_range(0, 99) < prr, 1'b0,
           $urandom_range(0, 99) < prst);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0; resp_ready = 1'b0; eom = 1'b0;
    fpu_out = '0; fpu_flags = '0;
    s_iv = 1'b0; s_rr = 1'b0; s_eom = 1'b0; s_rst = 1'b1; s_fo = '0; s_ff = '0;

    repeat (3) step_r(0, 0, 0, 1);
    step_r(0, 1, 0, 0);
    step_r(0, 1, 0, 0);

    // Single operation, plain result
    step(1, 1, 0, 0, 32'h4040_0000, 8'h00);
    repeat (4) step(0, 1, 0, 0, 32'h4040_0000, 8'h00);
    chk("single_in_flight_before", in_flight, 1);
    step(0, 1, 0, 0, 32'h4040_0000, 8'h00);
    chk("single_in_flight_after", in_flight, 0);
    chk("single_valid", resp_valid, 1);
    chk("single_data", resp_data, 40'h00_4040_0000);
    repeat (2) step_r(0, 1, 0, 0);

    // Divide-by-zero / infinity flags
    step(1, 1, 0, 0, 32'h7F80_0000, 8'h81);
    repeat (5) step(0, 1, 0, 0, 32'h7F80_0000, 8'h81);
    chk("dbz_valid", resp_valid, 1);
    chk("dbz_data", resp_data, 40'h81_7F80_0000);
    chk("dbz_flag_bits", {resp_data[32 + FLG_INF], resp_data[32 + FLG_DBZ]}, 2'b11);
    repeat (2) step_r(0, 1, 0, 0);

    // Backpressure: continuous issue with the consumer stalled
    repeat (12) step_r(1, 0, 0, 0);
    repeat (2) step_r(0, 0, 0, 0);
    chk("bp_fifo_count", fifo_count, 8);
    chk("bp_in_flight", in_flight, 0);
    chk("bp_issue_ready", issue_ready, 0);
    chk("bp_proto_err", proto_err, 1);
    step_r(0, 1, 0, 0);
    step_r(0, 1, 0, 0);
    chk("bp_ready_after_pop", issue_ready, 1);
    repeat (10) step_r(0, 1, 0, 0);
    chk("bp_drained", fifo_count, 0);

    // Randomised traffic with occasional resets
    repeat (400) step_p(60, 60, 2);
    repeat (3) step_p(70, 30, 0);

    // Reset in the middle of work
    step_r(0, 0, 0, 1);
    step_r(0, 0, 0, 0);
    repeat (5) step_r(1, 0, 0, 0);
    repeat (3) step_r(0, 0, 0, 0);
    chk("mid_in_flight", in_flight, 2);
    chk("mid_fifo_count", fifo_count, 3);
    step_r(0, 1, 0, 1);
    step_r(0, 1, 0, 0);
    repeat (10) step_r(0, 1, 0, 0);
    chk("mid_flushed_count", fifo_count, 0);
    chk("mid_flushed_valid", resp_valid, 0);

    // Drain at end of message with three operations outstanding
    step_r(1, 1, 0, 0);
    step_r(1, 1, 0, 0);
    step_r(1, 1, 1, 0);
    step_r(0, 1, 1, 0);
    chk("drain_in_flight", in_flight, 3);
    chk("drain_issue_ready", issue_ready, 0);
    repeat (15) step_r(0, 1, 1, 0);
    chk("drain_done", done, 1);
    repeat (6) step_p(50, 50, 0);
    chk("drain_done_held", done, 1);

    // Random traffic once more, then a final reset
    step_r(0, 0, 0, 1);
    repeat (200) step_p(70, 50, 1);
    step_r(0, 0, 0, 1);
    step_r(0, 0, 0, 0);
    chk("final_in_flight", in_flight, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
